// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor. Operands are latched on start, then DIGIT
// bits are summed per cycle LSB-first with a registered carry between
// digits. Flags and result are published only when the last digit
// completes, so partial sums are never visible on the outputs.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be 2..64 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] da, db;
  logic [DIGIT:0]   dsum;
  logic             msb_cin;
  logic [WIDTH-1:0] acc_next;

  // One digit of the ripple sum; carry into the digit MSB is recovered from
  // the sum bit so overflow works for any DIGIT, including DIGIT=1.
  always_comb begin
    da       = a_q[DIGIT-1:0];
    db       = b_q[DIGIT-1:0];
    dsum     = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
    msb_cin  = dsum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
    acc_next = WIDTH'({dsum[DIGIT-1:0], acc_q} >> DIGIT);
  end

  // Next-state and datapath control for IDLE/RUN/DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dsum[DIGIT];
        acc_d   = acc_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          res_d   = acc_next;
          cout_d  = dsum[DIGIT];
          ovf_d   = msb_cin ^ dsum[DIGIT];
          zero_d  = (acc_next == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: an 8-bit/1-bit-digit instance and a
// 16-bit/4-bit-digit instance run side by side, each with its own driver,
// expectation queue and monitor.
module tb_serial_add_sub;

  localparam int unsigned WA = 8,  DA = 1, NA = WA / DA;
  localparam int unsigned WB = 16, DB = 4, NB = WB / DB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    int unsigned due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea_pop, eb_pop;
  logic [WA-1:0] hold_a = '0;
  logic [WB-1:0] hold_b = '0;

  // Instance A signals
  logic          ra_n, sa_start, sa_sub;
  logic [WA-1:0] sa_a, sa_b, sa_res;
  logic          sa_busy, sa_done, sa_cout, sa_ovf, sa_zero;
  // Instance B signals
  logic          rb_n, sb_start, sb_sub;
  logic [WB-1:0] sb_a, sb_b, sb_res;
  logic          sb_busy, sb_done, sb_cout, sb_ovf, sb_zero;

  serial_add_sub #(.WIDTH(WA), .DIGIT(DA)) dut_a (
    .clk(clk), .rst_n(ra_n), .start(sa_start), .sub(sa_sub), .a(sa_a), .b(sa_b),
    .busy(sa_busy), .done(sa_done), .result(sa_res), .c_out(sa_cout),
    .overflow(sa_ovf), .zero(sa_zero)
  );

  serial_add_sub #(.WIDTH(WB), .DIGIT(DB)) dut_b (
    .clk(clk), .rst_n(rb_n), .start(sb_start), .sub(sb_sub), .a(sb_a), .b(sb_b),
    .busy(sb_busy), .done(sb_done), .result(sb_res), .c_out(sb_cout),
    .overflow(sb_ovf), .zero(sb_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int unsigned w, input logic [15:0] x,
                                 input logic [15:0] y, input logic s);
    exp_t e;
    longint m, half, xi, yi, sx, sy, tv, full;
    m    = longint'(1) << w;
    half = m / 2;
    xi   = longint'(x);
    yi   = longint'(y);
    full = s ? xi - yi : xi + yi;
    e.res  = 16'(((full % m) + m) % m);
    e.cout = s ? (xi >= yi) : (full >= m);
    sx = (xi >= half) ? xi - m : xi;
    sy = (yi >= half) ? yi - m : yi;
    tv = s ? sx - sy : sx + sy;
    e.ovf  = (tv >= half) || (tv < -half);
    e.zero = (e.res == 16'd0);
    e.due  = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic o, input logic z);
    exp_t e;
    e.res = r; e.cout = c; e.ovf = o; e.zero = z; e.due = 0;
    return e;
  endfunction

  // Drive one request on instance A (caller is at a negedge with DUT idle).
  task automatic issue_a(input logic [WA-1:0] x, input logic [WA-1:0] y, input logic s, input exp_t e);
    exp_t t;
    t = e;
    sa_a = x; sa_b = y; sa_sub = s; sa_start = 1'b1;
    @(posedge clk); #1;
    t.due = cyc + NA;
    qa.push_back(t);
    sa_start = 1'b0;
  endtask

  task automatic issue_b(input logic [WB-1:0] x, input logic [WB-1:0] y, input logic s, input exp_t e);
    exp_t t;
    t = e;
    sb_a = x; sb_b = y; sb_sub = s; sb_start = 1'b1;
    @(posedge clk); #1;
    t.due = cyc + NB;
    qb.push_back(t);
    sb_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    int g = 0;
    while (qa.size() != 0 && g < 200) begin @(negedge clk); g++; end
    if (qa.size() != 0) begin
      checks++; errors++;
      $display("FAIL a_done_timeout: got no done, expected done within 200 cycles");
      qa.delete();
    end
    @(posedge clk);
  endtask

  task automatic wait_idle_b();
    int g = 0;
    while (qb.size() != 0 && g < 200) begin @(negedge clk); g++; end
    if (qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL b_done_timeout: got no done, expected done within 200 cycles");
      qb.delete();
    end
    @(posedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_busy"}, sa_busy, 0);
    chk({tag, "_done"}, sa_done, 0);
    chk({tag, "_result"}, sa_res, 0);
    chk({tag, "_zero"}, sa_zero, 1);
    chk({tag, "_c_out"}, sa_cout, 0);
    chk({tag, "_overflow"}, sa_ovf, 0);
  endtask

  // Monitor A: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (sa_done) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        ea_pop = qa.pop_front();
        chk("a_result", sa_res, ea_pop.res);
        chk("a_c_out", sa_cout, ea_pop.cout);
        chk("a_overflow", sa_ovf, ea_pop.ovf);
        chk("a_zero", sa_zero, ea_pop.zero);
        chk("a_latency", cyc, ea_pop.due);
        chk("a_busy_in_done", sa_busy, 0);
        hold_a = ea_pop.res[WA-1:0];
      end
    end else if (sa_busy) begin
      chk("a_result_held_while_busy", sa_res, hold_a);
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (sb_done) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        eb_pop = qb.pop_front();
        chk("b_result", sb_res, eb_pop.res);
        chk("b_c_out", sb_cout, eb_pop.cout);
        chk("b_overflow", sb_ovf, eb_pop.ovf);
        chk("b_zero", sb_zero, eb_pop.zero);
        chk("b_latency", cyc, eb_pop.due);
        chk("b_busy_in_done", sb_busy, 0);
        hold_b = eb_pop.res;
      end
    end else if (sb_busy) begin
      chk("b_result_held_while_busy", sb_res, hold_b);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus for instance A: directed cases, then random operations.
  task automatic run_a();
    logic [WA-1:0] x, y;
    logic s;
    ra_n = 1'b1; sa_start = 1'b0; sa_sub = 1'b0; sa_a = '0; sa_b = '0;
    #22;                       // between edges: reset must act without a clock
    ra_n = 1'b0; hold_a = '0;
    #1 chk_reset_a("a_reset");
    // release and start together: accepted on the first edge with rst_n high
    @(negedge clk); ra_n = 1'b1;
    issue_a(8'h3C, 8'h45, 1'b0, mk(16'h81, 1'b0, 1'b1, 1'b0));
    wait_idle_a();
    @(negedge clk); issue_a(8'h10, 8'h10, 1'b1, mk(16'h00, 1'b1, 1'b0, 1'b1));
    wait_idle_a();
    @(negedge clk); issue_a(8'h00, 8'h01, 1'b1, mk(16'hFF, 1'b0, 1'b0, 1'b0));
    wait_idle_a();
    @(negedge clk); issue_a(8'hFF, 8'h01, 1'b0, mk(16'h00, 1'b1, 1'b0, 1'b1));
    wait_idle_a();
    // start re-pulsed mid-RUN with new operands, operands left changed
    @(negedge clk); issue_a(8'h12, 8'h34, 1'b0, mk(16'h46, 1'b0, 1'b0, 1'b0));
    repeat (3) @(negedge clk);
    sa_a = 8'hAA; sa_b = 8'h55; sa_sub = 1'b1; sa_start = 1'b1;
    @(negedge clk); sa_start = 1'b0;
    wait_idle_a();
    repeat (12) @(negedge clk);
    // start held high: second acceptance in the IDLE cycle after DONE
    @(negedge clk);
    sa_a = 8'h70; sa_b = 8'h20; sa_sub = 1'b0; sa_start = 1'b1;
    @(posedge clk); #1;
    qa.push_back('{res: 16'h90, cout: 1'b0, ovf: 1'b1, zero: 1'b0, due: cyc + NA});
    qa.push_back('{res: 16'h90, cout: 1'b0, ovf: 1'b1, zero: 1'b0, due: cyc + 2 * NA + 2});
    repeat (NA + 2) @(posedge clk);
    #1 sa_start = 1'b0;
    wait_idle_a();
    // abort with reset at RUN cycle 4
    @(negedge clk); issue_a(8'h01, 8'h02, 1'b0, mk(16'h03, 1'b0, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    ra_n = 1'b0; qa.delete(); hold_a = '0;
    #1 chk_reset_a("a_abort");
    @(negedge clk); ra_n = 1'b1;
    repeat (15) @(negedge clk);
    #1 chk_reset_a("a_after_abort");
    // random operations
    for (int i = 0; i < 300; i++) begin
      x = WA'($urandom); y = WA'($urandom); s = 1'($urandom);
      @(negedge clk); issue_a(x, y, s, model(WA, 16'(x), 16'(y), s));
      wait_idle_a();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic run_b();
    logic [WB-1:0] x, y;
    logic s;
    rb_n = 1'b0; sb_start = 1'b0; sb_sub = 1'b0; sb_a = '0; sb_b = '0; hold_b = '0;
    repeat (3) @(negedge clk);
    rb_n = 1'b1;
    @(negedge clk); issue_b(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    wait_idle_b();
    for (int i = 0; i < 1000; i++) begin
      x = WB'($urandom); y = WB'($urandom); s = 1'($urandom);
      @(negedge clk); issue_b(x, y, s, model(WB, x, y, s));
      wait_idle_b();
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    repeat (20) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
